// File: rtl/ram_access_arbiter_pkg.sv
// Shared types for the dataset RAM arbiter: FSM state encoding and client ids.
package ram_access_arbiter_pkg;

  localparam int ARB_ADDR_WIDTH = 11;
  localparam int ARB_DATA_WIDTH = 192;
  localparam int ARB_NUM_DP     = 5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_READ      = 2'd2,
    ST_READ_WAIT = 2'd3
  } state_e;

  // Encoding doubles as the bit index in the picker request/grant vectors.
  typedef enum logic {
    CLIENT_WR = 1'b0,
    CLIENT_RD = 1'b1
  } client_e;

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Client/status bundle of the dataset RAM arbiter; the bidirectional RAM data bus
// stays a plain module port so the tri-state driver lives at module level.
interface ram_access_arbiter_if
  import ram_access_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH = ARB_DATA_WIDTH
);
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_gnt;
  logic                  wr_err;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_gnt;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  ram_oe;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [ADDR_WIDTH-1:0] wr_count;
  logic                  load_done;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr,
    input  wr_gnt, wr_err, rd_gnt, rd_valid, rd_data,
    input  ram_oe, ram_we, ram_addr, wr_count, load_done
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
    output wr_gnt, wr_err, rd_gnt, rd_valid, rd_data,
    output ram_oe, ram_we, ram_addr, wr_count, load_done
  );

endinterface

// File: rtl/ram_access_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the client
// that was not served last.
module rr_pick2
  import ram_access_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  client_e    last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == CLIENT_WR) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Owner of the single-port dataset RAM: arbitrates loader writes against compute
// reads and holds off reads of words that have not been loaded yet.
//
// state        | meaning
// ST_IDLE      | pick next access; rd_valid/wr_err pulses land here
// ST_WRITE     | RAM write strobe, wr_gnt, bus driven with latched data
// ST_READ      | RAM output enabled, rd_gnt
// ST_READ_WAIT | RAM output enabled, read data captured at end of cycle
module ram_access_arbiter
  import ram_access_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH = ARB_DATA_WIDTH,
  parameter int NUM_DP     = ARB_NUM_DP
) (
  input  logic                  CLK,
  input  logic                  RST,
  ram_access_arbiter_if.slave   bus,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  localparam logic [ADDR_WIDTH-1:0] NUM_DP_W = ADDR_WIDTH'(NUM_DP);

  state_e                state_q, state_d;
  client_e               last_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [ADDR_WIDTH-1:0] wr_count_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  wr_err_q;
  logic                  load_done;
  logic [1:0]            elig;
  logic [1:0]            pick;
  logic                  ram_we_int;

  assign load_done = (wr_count_q == NUM_DP_W);
  assign elig[CLIENT_WR] = bus.wr_req & ~load_done;
  // Only words already stored may be read, so compute can trail the loader.
  assign elig[CLIENT_RD] = bus.rd_req & (bus.rd_addr < wr_count_q);

  rr_pick2 u_pick (
    .req  (elig),
    .last (last_q),
    .gnt  (pick)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pick[CLIENT_WR])      state_d = ST_WRITE;
        else if (pick[CLIENT_RD]) state_d = ST_READ;
      end
      ST_WRITE:     state_d = ST_IDLE;
      ST_READ:      state_d = ST_READ_WAIT;
      ST_READ_WAIT: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      last_q     <= CLIENT_RD;
      addr_q     <= '0;
      wr_data_q  <= '0;
      wr_count_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= (state_q == ST_READ_WAIT);
      wr_err_q   <= (state_q == ST_IDLE) & bus.wr_req & load_done;
      // Latch the winner's request so the RAM side is driven purely from flops.
      if (state_q == ST_IDLE && pick[CLIENT_WR]) begin
        addr_q    <= bus.wr_addr;
        wr_data_q <= bus.wr_data;
      end else if (state_q == ST_IDLE && pick[CLIENT_RD]) begin
        addr_q <= bus.rd_addr;
      end
      if (state_q == ST_WRITE) begin
        wr_count_q <= wr_count_q + ADDR_WIDTH'(1);
        last_q     <= CLIENT_WR;
      end
      if (state_q == ST_READ_WAIT) begin
        rd_data_q <= ram_data;
        last_q    <= CLIENT_RD;
      end
    end
  end

  assign ram_we_int    = (state_q == ST_WRITE);
  assign bus.ram_we    = ram_we_int;
  assign bus.ram_oe    = (state_q == ST_READ) || (state_q == ST_READ_WAIT);
  assign bus.ram_addr  = (state_q == ST_IDLE) ? '0 : addr_q;
  assign bus.wr_gnt    = ram_we_int;
  assign bus.rd_gnt    = (state_q == ST_READ);
  assign bus.wr_err    = wr_err_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.wr_count  = wr_count_q;
  assign bus.load_done = load_done;

  assign ram_data = ram_we_int ? wr_data_q : 'z;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a small behavioural RAM on the shared bus.
module tb_ram_access_arbiter;
  import ram_access_arbiter_pkg::*;

  localparam int AW = 11;
  localparam int DW = 192;

  logic clk = 1'b0;
  logic rst;
  wire  [DW-1:0] ram_data;
  logic [DW-1:0] mem [8];
  int   ram_we_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic mon_en = 1'b0;

  ram_access_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_DP(5)) dut (
    .CLK      (clk),
    .RST      (rst),
    .bus      (bus),
    .ram_data (ram_data)
  );

  always #5 clk = ~clk;

  assign ram_data = bus.ram_oe ? mem[bus.ram_addr[2:0]] : 'z;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr[2:0]] <= ram_data;
      ram_we_cnt <= ram_we_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic bus_free(input logic [DW-1:0] d);
    return $isunknown(d) || (d == '0);
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("bus_oe_we_excl", DW'(bus.ram_oe & bus.ram_we), DW'(0));
      if (!bus.ram_oe && !bus.ram_we)
        chk("bus_released", DW'(bus_free(ram_data)), DW'(1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int exp_wait);
    int waited;
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    waited = 0;
    do begin
      step();
      waited++;
    end while (!bus.wr_gnt && waited < 20);
    chk("wr_gnt_wait", DW'(waited), DW'(exp_wait));
    chk("wr_bus_ctl", DW'({bus.ram_we, bus.ram_oe}), DW'(2'b10));
    chk("wr_bus_addr", DW'(bus.ram_addr), DW'(a));
    chk("wr_bus_data", ram_data, d);
    bus.wr_req = 1'b0;
  endtask

  initial begin
    int w;
    int n_g;
    logic [3:0] gseq;
    int gcyc [4];
    logic [DW-1:0] rd_first;
    logic rd_seen;

    rst = 1'b1;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    repeat (3) step();
    chk("rst_flags", DW'({bus.wr_gnt, bus.wr_err, bus.rd_gnt, bus.rd_valid,
                         bus.ram_oe, bus.ram_we, bus.load_done}), DW'(0));
    chk("rst_count", DW'(bus.wr_count), DW'(0));
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_flags", DW'({bus.wr_gnt, bus.wr_err, bus.rd_gnt, bus.rd_valid,
                            bus.ram_oe, bus.ram_we, bus.load_done}), DW'(0));
      chk("idle_addr_count", DW'({bus.ram_addr, bus.wr_count}), DW'(0));
      chk("idle_rd_data", bus.rd_data, DW'(0));
    end

    // load word 0, then a read of word 2 must stall until word 2 is stored
    do_write(11'd0, DW'('hA5), 1);
    step();
    chk("wr_count_1", DW'(bus.wr_count), DW'(1));
    bus.rd_req = 1'b1; bus.rd_addr = 11'd2;
    repeat (2) begin
      step();
      chk("rd_stall", DW'(bus.rd_gnt), DW'(0));
    end
    do_write(11'd1, DW'('hA6), 1);
    step();
    chk("wr_count_2", DW'(bus.wr_count), DW'(2));
    chk("rd_stall_2", DW'(bus.rd_gnt), DW'(0));
    do_write(11'd2, DW'('hA7), 1);
    w = 0;
    do begin
      step();
      w++;
    end while (!bus.rd_gnt && w < 20);
    chk("rd_gnt_wait", DW'(w), DW'(2));
    chk("rd_bus", DW'({bus.ram_oe, bus.ram_we, bus.ram_addr}), DW'({1'b1, 1'b0, 11'd2}));
    bus.rd_req = 1'b0;
    step();
    chk("rd_wait_bus", DW'({bus.rd_gnt, bus.rd_valid, bus.ram_oe, bus.ram_addr}),
        DW'({1'b0, 1'b0, 1'b1, 11'd2}));
    step();
    chk("rd_valid", DW'(bus.rd_valid), DW'(1));
    chk("rd_data_a7", bus.rd_data, DW'('hA7));
    step();
    chk("rd_valid_pulse", DW'(bus.rd_valid), DW'(0));
    chk("rd_data_held", bus.rd_data, DW'('hA7));

    // back-to-back writes: second grant two cycles after the first
    do_write(11'd3, DW'('hA8), 1);
    do_write(11'd4, DW'('hA9), 2);
    chk("wr_count_4", DW'({bus.wr_count, bus.load_done}), DW'({11'd4, 1'b0}));
    step();
    chk("load_done", DW'({bus.wr_count, bus.load_done}), DW'({11'd5, 1'b1}));

    bus.wr_req = 1'b1; bus.wr_addr = 11'd5; bus.wr_data = DW'('hAA);
    step();
    chk("wr_err_pulse", DW'({bus.wr_err, bus.wr_gnt, bus.ram_we}), DW'(3'b100));
    bus.wr_req = 1'b0;
    step();
    chk("wr_err_clear", DW'(bus.wr_err), DW'(0));
    repeat (2) step();
    chk("ram_untouched", DW'(ram_we_cnt), DW'(5));
    chk("load_held", DW'({bus.wr_count, bus.load_done}), DW'({11'd5, 1'b1}));

    // reset while a read is in READ_WAIT
    bus.rd_req = 1'b1; bus.rd_addr = 11'd1;
    step();
    chk("rst_rd_gnt", DW'(bus.rd_gnt), DW'(1));
    bus.rd_req = 1'b0;
    step();
    chk("rst_in_wait", DW'({bus.ram_oe, bus.rd_gnt}), DW'(2'b10));
    rst = 1'b1;
    step();
    chk("rst_abort_flags", DW'({bus.rd_valid, bus.ram_oe, bus.load_done}), DW'(0));
    chk("rst_abort_count", DW'(bus.wr_count), DW'(0));
    chk("rst_abort_data", bus.rd_data, DW'(0));
    rst = 1'b0;
    step();
    chk("rst_no_rd_valid", DW'(bus.rd_valid), DW'(0));

    // both clients held: writer wins first, then strict alternation
    bus.wr_req = 1'b1; bus.wr_addr = 11'd0; bus.wr_data = DW'('hB0);
    bus.rd_req = 1'b1; bus.rd_addr = 11'd0;
    n_g = 0; gseq = '0; rd_seen = 1'b0; rd_first = '0;
    for (int i = 0; i < 4; i++) gcyc[i] = 0;
    for (int c = 1; c <= 20 && n_g < 4; c++) begin
      step();
      if (bus.rd_valid && !rd_seen) begin
        rd_seen = 1'b1;
        rd_first = bus.rd_data;
      end
      if (bus.wr_gnt) begin
        gseq[3-n_g] = 1'b0;
        gcyc[n_g] = c;
        n_g++;
        bus.wr_addr = bus.wr_addr + 11'd1;
        bus.wr_data = bus.wr_data + DW'(1);
      end else if (bus.rd_gnt) begin
        gseq[3-n_g] = 1'b1;
        gcyc[n_g] = c;
        n_g++;
      end
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    chk("alt_grants", DW'(n_g), DW'(4));
    chk("alt_order", DW'(gseq), DW'(4'b0101));
    chk("alt_cyc0", DW'(gcyc[0]), DW'(1));
    chk("alt_cyc1", DW'(gcyc[1]), DW'(3));
    chk("alt_cyc2", DW'(gcyc[2]), DW'(6));
    chk("alt_cyc3", DW'(gcyc[3]), DW'(8));
    chk("alt_rd_data", rd_first, DW'('hB0));
    repeat (4) step();
    chk("alt_wr_count", DW'(bus.wr_count), DW'(2));

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
